// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator: opcodes, FSM states, flag bit positions.
package calc_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Bit positions inside flags = {err, ovf_carry, negative, zero}
    localparam int unsigned FLAG_ZERO = 0;
    localparam int unsigned FLAG_NEG  = 1;
    localparam int unsigned FLAG_OVF  = 2;
    localparam int unsigned FLAG_ERR  = 3;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, N cycles per division.
// Ports: clk, rst_n (sync, active-low), i_start (load operands), i_dividend, i_divisor,
//        o_done (one-cycle pulse when quotient/remainder are final), o_quotient, o_remainder.
module seq_divider #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_quo;
    logic [N-1:0]  r_dvs;
    logic [CW-1:0] r_cnt;
    logic          r_done;

    logic [N:0]    w_rem_sh;
    logic [N:0]    w_diff;
    logic          w_sub_ok;

    // Shift next dividend bit into the partial remainder and trial-subtract the divisor
    assign w_rem_sh = {r_rem, r_quo[N-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_sub_ok = (w_rem_sh >= {1'b0, r_dvs});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem <= '0;
                r_quo <= i_dividend;
                r_dvs <= i_divisor;
                r_cnt <= CW'(N);
            end else if (r_cnt != '0) begin
                // Dividend bits leave r_quo from the top while quotient bits enter at the bottom
                r_rem <= w_sub_ok ? w_diff[N-1:0] : w_rem_sh[N-1:0];
                r_quo <= {r_quo[N-2:0], w_sub_ok};
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/seq_calculator.sv
// Sequential N-bit calculator with valid/ready handshakes and a multi-cycle divider.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready request handshake with
//        op_select, operand1, operand2; out_valid/out_ready result handshake with
//        resultado (2N bits) and flags {err, ovf_carry, negative, zero}.
module seq_calculator
    import calc_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     op_select,
    input  logic [N-1:0]   operand1,
    input  logic [N-1:0]   operand2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] resultado,
    output logic [3:0]     flags
);

    localparam int unsigned W2 = 2 * N;

    state_e        r_state;
    logic [3:0]    r_op;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_out_valid;
    logic [W2-1:0] r_result;
    logic [3:0]    r_flags;

    logic          w_accept;
    logic          w_div_start;
    logic          w_div_done;
    logic [N-1:0]  w_quo;
    logic [N-1:0]  w_rem;
    logic [N:0]    w_sum;
    logic [N-1:0]  w_diff;
    logic [W2-1:0] w_prod;
    logic [W2-1:0] w_shl;
    logic [W2-1:0] w_res;
    logic [3:0]    w_flags;

    assign w_accept    = in_valid && (r_state == ST_IDLE);
    // Division by zero skips the divider and resolves in the single-cycle EXEC path
    assign w_div_start = w_accept && ((op_select == OP_DIV) || (op_select == OP_MOD))
                         && (operand2 != '0);

    seq_divider #(.N(N)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_div_start),
        .i_dividend  (operand1),
        .i_divisor   (operand2),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = r_a - r_b;
    assign w_prod = W2'(r_a) * W2'(r_b);
    assign w_shl  = W2'(r_a) << r_b;

    // Result and flags from the captured operands (divider outputs for div/mod)
    always_comb begin
        w_res   = '0;
        w_flags = '0;
        case (r_op)
            OP_ADD: begin
                w_res             = W2'(w_sum[N-1:0]);
                w_flags[FLAG_OVF] = w_sum[N];
            end
            OP_SUB: begin
                w_res             = W2'(w_diff);
                w_flags[FLAG_OVF] = (r_a < r_b);
                w_flags[FLAG_NEG] = w_diff[N-1];
            end
            OP_MUL: begin
                w_res             = w_prod;
                w_flags[FLAG_OVF] = |w_prod[W2-1:N];
            end
            OP_DIV: begin
                if (r_b == '0) begin
                    w_res             = W2'({N{1'b1}});
                    w_flags[FLAG_ERR] = 1'b1;
                end else begin
                    w_res = W2'(w_quo);
                end
            end
            OP_MOD: begin
                if (r_b == '0) begin
                    w_res             = W2'(r_a);
                    w_flags[FLAG_ERR] = 1'b1;
                end else begin
                    w_res = W2'(w_rem);
                end
            end
            OP_AND: w_res = W2'(r_a & r_b);
            OP_OR:  w_res = W2'(r_a | r_b);
            OP_XOR: w_res = W2'(r_a ^ r_b);
            OP_SHL: begin
                w_res             = w_shl;
                w_flags[FLAG_OVF] = |w_shl[W2-1:N];
            end
            OP_SHR: w_res = W2'(r_a >> r_b);
            default: w_flags[FLAG_ERR] = 1'b1;
        endcase
        w_flags[FLAG_ZERO] = (w_res == '0);
    end

    // Control FSM with registered result, flags and out_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op_select;
                        r_a     <= operand1;
                        r_b     <= operand2;
                        r_state <= w_div_start ? ST_DIV : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result    <= w_res;
                    r_flags     <= w_flags;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_result    <= w_res;
                        r_flags     <= w_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign resultado = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator (N = 4): directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_seq_calculator;

    localparam int unsigned N = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op_select;
    logic [3:0] operand1;
    logic [3:0] operand2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] resultado;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;

    seq_calculator #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_select (op_select),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (resultado),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result and {err, carry, negative, zero} from plain integer arithmetic
    function automatic void model(input int op, input int a, input int b,
                                  output logic [7:0] res, output logic [3:0] fl);
        int r;
        bit err, ovf, neg;
        r = 0; err = 0; ovf = 0; neg = 0;
        case (op)
            0: begin r = (a + b) % 16; ovf = (a + b) >= 16; end
            1: begin r = (a - b + 16) % 16; ovf = a < b; neg = r >= 8; end
            2: begin r = a * b; ovf = r >= 16; end
            3: begin if (b == 0) begin r = 15; err = 1; end else r = a / b; end
            4: begin if (b == 0) begin r = a; err = 1; end else r = a % b; end
            5: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            8: begin r = (b >= 8) ? 0 : (a * (1 << b)) % 256; ovf = r >= 16; end
            9: r = (b >= 4) ? 0 : a / (1 << b);
            default: err = 1;
        endcase
        res = 8'(r);
        fl  = {err, ovf, neg, (r == 0)};
    endfunction

    function automatic int exp_latency(input int op, input int b);
        return ((op == 3 || op == 4) && b != 0) ? N + 1 : 1;
    endfunction

    // Present one request at a negedge while in_ready; returns right after the accept edge
    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid  = 1'b1;
        op_select = op;
        operand1  = a;
        operand2  = b;
        @(posedge clk);
    endtask

    // Counts edges from accept until out_valid is seen at a negedge (bounded)
    task automatic wait_out(output int lat);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || resultado !== 8'h00 || flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b res=%h flags=%b, want 0 1 00 0000",
                     out_valid, in_ready, resultado, flags);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat;
        send(4'd0, 4'd9, 4'd8);
        wait_out(lat);
        checks++;
        if (lat !== 1 || resultado !== 8'h01 || flags !== 4'b0100) begin
            errors++;
            $display("FAIL add_9_8: lat=%0d res=%h flags=%b, want 1 01 0100", lat, resultado, flags);
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat;
        send(4'd2, 4'd15, 4'd15);
        wait_out(lat);
        checks++;
        if (lat !== 1 || resultado !== 8'hE1 || flags !== 4'b0100) begin
            errors++;
            $display("FAIL mul_15_15: lat=%0d res=%h flags=%b, want 1 e1 0100", lat, resultado, flags);
        end
        @(negedge clk);
    endtask

    task automatic test_div();
        int lat;
        send(4'd3, 4'd13, 4'd4);
        wait_out(lat);
        checks++;
        if (lat !== 5 || resultado !== 8'h03 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL div_13_4: lat=%0d res=%h flags=%b, want 5 03 0000", lat, resultado, flags);
        end
        @(negedge clk);
        send(4'd4, 4'd13, 4'd4);
        wait_out(lat);
        checks++;
        if (lat !== 5 || resultado !== 8'h01 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL mod_13_4: lat=%0d res=%h flags=%b, want 5 01 0000", lat, resultado, flags);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat;
        send(4'd3, 4'd7, 4'd0);
        wait_out(lat);
        checks++;
        if (lat !== 1 || resultado !== 8'h0F || flags !== 4'b1000) begin
            errors++;
            $display("FAIL div_7_0: lat=%0d res=%h flags=%b, want 1 0f 1000", lat, resultado, flags);
        end
        @(negedge clk);
        send(4'd4, 4'd7, 4'd0);
        wait_out(lat);
        checks++;
        if (lat !== 1 || resultado !== 8'h07 || flags !== 4'b1000) begin
            errors++;
            $display("FAIL mod_7_0: lat=%0d res=%h flags=%b, want 1 07 1000", lat, resultado, flags);
        end
        @(negedge clk);
    endtask

    task automatic test_sub_backpressure();
        int lat;
        out_ready = 1'b0;
        send(4'd1, 4'd3, 4'd5);
        wait_out(lat);
        checks++;
        if (lat !== 1 || resultado !== 8'h0E || flags !== 4'b0110) begin
            errors++;
            $display("FAIL sub_3_5: lat=%0d res=%h flags=%b, want 1 0e 0110", lat, resultado, flags);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || resultado !== 8'h0E || flags !== 4'b0110) begin
                errors++;
                $display("FAIL sub_hold[%0d]: out_valid=%b in_ready=%b res=%h flags=%b, want 1 0 0e 0110",
                         i, out_valid, in_ready, resultado, flags);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sub_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        // Reset during the second divider cycle
        send(4'd3, 4'd13, 4'd4);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL div_abort_ready: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL div_abort_beat: out_valid cycles=%0d, want 0", seen);
        end
        send(4'd12, 4'd5, 4'd6);
        wait_out(lat);
        checks++;
        if (lat !== 1 || resultado !== 8'h00 || flags !== 4'b1001) begin
            errors++;
            $display("FAIL reserved_12: lat=%0d res=%h flags=%b, want 1 00 1001", lat, resultado, flags);
        end
        @(negedge clk);
        // Reset while a result is parked in DONE
        out_ready = 1'b0;
        send(4'd0, 4'd9, 4'd8);
        wait_out(lat);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || resultado !== 8'h00 || flags !== 4'h0) begin
            errors++;
            $display("FAIL done_abort: out_valid=%b in_ready=%b res=%h flags=%b, want 0 1 00 0000",
                     out_valid, in_ready, resultado, flags);
        end
    endtask

    task automatic test_random();
        int lat;
        int op, a, b, hold;
        logic [7:0] eres;
        logic [3:0] efl;
        for (int n = 0; n < 60; n++) begin
            op   = (n < 16) ? n : int'($urandom_range(0, 15));
            a    = int'($urandom_range(0, 15));
            b    = (n % 7 == 3) ? 0 : int'($urandom_range(0, 15));
            hold = int'($urandom_range(0, 2));
            model(op, a, b, eres, efl);
            out_ready = (hold == 0);
            send(4'(op), 4'(a), 4'(b));
            wait_out(lat);
            checks++;
            if (lat !== exp_latency(op, b) || resultado !== eres || flags !== efl) begin
                errors++;
                $display("FAIL rand op=%0d a=%0d b=%0d: lat=%0d res=%h flags=%b, want %0d %h %b",
                         op, a, b, lat, resultado, flags, exp_latency(op, b), eres, efl);
            end
            if (hold != 0) begin
                repeat (hold) @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || resultado !== eres || flags !== efl) begin
                    errors++;
                    $display("FAIL rand_hold op=%0d: out_valid=%b res=%h flags=%b, want 1 %h %b",
                             op, out_valid, resultado, flags, eres, efl);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_select = '0;
        operand1  = '0;
        operand2  = '0;
        out_ready = 1'b1;
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_div_zero();
        test_sub_backpressure();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
